// File: rtl/clint_multi.sv
// Core-local interruptor for NHART harts behind an AXI4-Lite slave port.
// Holds a shared prescaled 64-bit mtime and a per-hart mtimecmp and msip.
// Raises time_intr[h] when mtime >= mtimecmp[h] and soft_intr[h] from msip[h].
module clint_multi #(
  parameter int NHART    = 1,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       axi_araddr,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [2:0]        axi_arprot,
  output logic [31:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  input  logic [31:0]       axi_awaddr,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [2:0]        axi_awprot,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  output logic [63:0]       mtime,
  output logic [NHART-1:0]  time_intr,
  output logic [NHART-1:0]  soft_intr
);

  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_MTIME_LO, REG_MTIME_HI, REG_ERR
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e        sel;
    logic [HW-1:0]   hart;
  } reg_dec_t;

  // Map a 16-bit offset to a register and hart; anything unmapped or misaligned is an error.
  function automatic reg_dec_t decode(input logic [15:0] addr);
    reg_dec_t    dec;
    logic [11:0] msip_idx;
    logic [10:0] cmp_idx;
    msip_idx = addr[13:2];
    cmp_idx  = addr[13:3];
    dec.sel  = REG_ERR;
    dec.hart = '0;
    if (addr[1:0] == 2'b00) begin
      if (addr == 16'hBFF8) begin
        dec.sel = REG_MTIME_LO;
      end else if (addr == 16'hBFFC) begin
        dec.sel = REG_MTIME_HI;
      end else if (addr[15:14] == 2'b00 && msip_idx < 12'(NHART)) begin
        dec.sel  = REG_MSIP;
        dec.hart = HW'(msip_idx);
      end else if (addr[15:14] == 2'b01 && cmp_idx < 11'(NHART)) begin
        dec.sel  = addr[2] ? REG_CMP_HI : REG_CMP_LO;
        dec.hart = HW'(cmp_idx);
      end
    end
    return dec;
  endfunction

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0]      mtime_q, mtime_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [NHART-1:0] msip_q;
  logic [63:0]      mtimecmp_q [NHART];
  logic             rvalid_q, bvalid_q;
  logic [31:0]      rdata_q, rd_val;
  logic [1:0]       rresp_q, bresp_q;
  reg_dec_t         rd_dec, wr_dec;
  logic             rd_fire, wr_fire, wr_ok, mtime_wr;
  logic             unused_inputs;

  assign rd_dec   = decode(axi_araddr[15:0]);
  assign wr_dec   = decode(axi_awaddr[15:0]);
  // Only one read and one write may be outstanding; readiness is simply "no response pending".
  assign rd_fire  = axi_arvalid && !rvalid_q;
  assign wr_fire  = axi_awvalid && axi_wvalid && !bvalid_q;
  assign wr_ok    = wr_fire && (wr_dec.sel != REG_ERR) && (axi_wstrb != 4'b0000);
  assign mtime_wr = wr_ok && (wr_dec.sel == REG_MTIME_LO || wr_dec.sel == REG_MTIME_HI);

  // Read data mux, sampled into rdata_q on the accept edge (pre-write values).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_val = '0;
    case (rd_dec.sel)
      REG_MSIP:     rd_val = {31'b0, msip_q[rd_dec.hart]};
      REG_CMP_LO:   rd_val = mtimecmp_q[rd_dec.hart][31:0];
      REG_CMP_HI:   rd_val = mtimecmp_q[rd_dec.hart][63:32];
      REG_MTIME_LO: rd_val = mtime_q[31:0];
      REG_MTIME_HI: rd_val = mtime_q[63:32];
      default:      rd_val = '0;
    endcase
  end

  // Next mtime/prescaler: a software write beats the tick and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (mtime_wr) begin
      presc_d = '0;
      if (wr_dec.sel == REG_MTIME_LO) begin
        mtime_d[31:0]  = merge_bytes(mtime_q[31:0], axi_wdata, axi_wstrb);
      end else begin
        mtime_d[63:32] = merge_bytes(mtime_q[63:32], axi_wdata, axi_wstrb);
      end
    end else if (presc_q == PW'(TICK_DIV - 1)) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Timer state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      mtime_q <= '0;
      presc_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
    end
  end

  // Per-hart msip and mtimecmp registers, written on a decoded write handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= '0;
      // NOTE: this small array is reset on purpose: all-ones compare values keep time_intr low out of reset.
      for (int h = 0; h < NHART; h++) mtimecmp_q[h] <= '1;
    end else if (wr_ok) begin
      case (wr_dec.sel)
        REG_MSIP:   if (axi_wstrb[0]) msip_q[wr_dec.hart] <= axi_wdata[0];
        REG_CMP_LO: mtimecmp_q[wr_dec.hart][31:0] <=
                      merge_bytes(mtimecmp_q[wr_dec.hart][31:0], axi_wdata, axi_wstrb);
        REG_CMP_HI: mtimecmp_q[wr_dec.hart][63:32] <=
                      merge_bytes(mtimecmp_q[wr_dec.hart][63:32], axi_wdata, axi_wstrb);
        default: ;
      endcase
    end
  end

  // AXI read and write response channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= (rd_dec.sel == REG_ERR) ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && axi_rready) begin
        rvalid_q <= 1'b0;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_dec.sel == REG_ERR) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Per-hart unsigned timer compare.
  always_comb begin
    time_intr = '0;
    for (int h = 0; h < NHART; h++) time_intr[h] = (mtime_q >= mtimecmp_q[h]);
  end

  assign axi_arready   = !rvalid_q;
  assign axi_awready   = !bvalid_q;
  assign axi_wready    = !bvalid_q;
  assign axi_rvalid    = rvalid_q;
  assign axi_rdata     = rdata_q;
  assign axi_rresp     = rresp_q;
  assign axi_bvalid    = bvalid_q;
  assign axi_bresp     = bresp_q;
  assign mtime         = mtime_q;
  assign soft_intr     = msip_q;
  assign unused_inputs = ^{axi_araddr[31:16], axi_awaddr[31:16], axi_arprot, axi_awprot};

endmodule

// File: tb/tb_clint_multi.sv
// Directed bench for clint_multi: dut_a (NHART=2, TICK_DIV=1) and dut_b (NHART=2, TICK_DIV=4)
// share one AXI stimulus bus; each test task observes the instance it targets.
module tb_clint_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  prot = '0;

  logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a;
  logic [31:0] rdata_a;
  logic [1:0]  rresp_a, bresp_a, time_intr_a, soft_intr_a;
  logic [63:0] mtime_a;
  logic        arready_b, rvalid_b, awready_b, wready_b, bvalid_b;
  logic [31:0] rdata_b;
  logic [1:0]  rresp_b, bresp_b, time_intr_b, soft_intr_b;
  logic [63:0] mtime_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;   // clock edges since reset released

  clint_multi #(.NHART(2), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready_a), .axi_arprot(prot),
    .axi_rdata(rdata_a), .axi_rresp(rresp_a), .axi_rvalid(rvalid_a), .axi_rready(rready),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready_a), .axi_awprot(prot),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready_a),
    .axi_bresp(bresp_a), .axi_bvalid(bvalid_a), .axi_bready(bready),
    .mtime(mtime_a), .time_intr(time_intr_a), .soft_intr(soft_intr_a)
  );

  clint_multi #(.NHART(2), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready_b), .axi_arprot(prot),
    .axi_rdata(rdata_b), .axi_rresp(rresp_b), .axi_rvalid(rvalid_b), .axi_rready(rready),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready_b), .axi_awprot(prot),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready_b),
    .axi_bresp(bresp_b), .axi_bvalid(bvalid_b), .axi_bready(bready),
    .mtime(mtime_b), .time_intr(time_intr_b), .soft_intr(soft_intr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete read; c_at is the edge count just before the accept edge.
  task automatic bus_read(input logic sel, input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp, output int c_at);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!(sel ? arready_b : arready_a) && n < 20) begin @(negedge clk); n++; end
    c_at = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!(sel ? rvalid_b : rvalid_a) && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL read_timeout addr=%h: rvalid never seen, required 1", addr);
    end
    data = sel ? rdata_b : rdata_a;
    resp = sel ? rresp_b : rresp_a;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // One complete write with AW and W presented together.
  task automatic bus_write(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!((sel ? awready_b : awready_a) && (sel ? wready_b : wready_a)) && n < 20) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!(sel ? bvalid_b : bvalid_a) && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL write_timeout addr=%h: bvalid never seen, required 1", addr);
    end
    resp = sel ? bresp_b : bresp_a;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({arready_a, awready_a, wready_a, rvalid_a, bvalid_a, rresp_a, bresp_a} !== 9'b111_00_0000) begin
      fails++;
      $display("FAIL reset_handshake_a: got %b required 111000000",
               {arready_a, awready_a, wready_a, rvalid_a, bvalid_a, rresp_a, bresp_a});
    end
    tests++;
    if ({arready_b, awready_b, wready_b, rvalid_b, bvalid_b, rresp_b, bresp_b} !== 9'b111_00_0000) begin
      fails++;
      $display("FAIL reset_handshake_b: got %b required 111000000",
               {arready_b, awready_b, wready_b, rvalid_b, bvalid_b, rresp_b, bresp_b});
    end
    tests++;
    if (rdata_a !== 32'h0 || mtime_a !== 64'h0 || mtime_b !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h mtime_a=%h mtime_b=%h required all 0", rdata_a, mtime_a, mtime_b);
    end
    tests++;
    if ({time_intr_a, soft_intr_a, time_intr_b, soft_intr_b} !== 8'h00) begin
      fails++;
      $display("FAIL reset_intr: got %b required 00000000",
               {time_intr_a, soft_intr_a, time_intr_b, soft_intr_b});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mtime_read();
    logic [31:0] d;
    logic [1:0]  r;
    int          c;
    bus_read(1'b0, 32'h4008, d, r, c);
    tests++;
    if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin
      fails++;
      $display("FAIL cmp1_lo_reset: got %h/%b required ffffffff/00", d, r);
    end
    bus_read(1'b0, 32'h400C, d, r, c);
    tests++;
    if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin
      fails++;
      $display("FAIL cmp1_hi_reset: got %h/%b required ffffffff/00", d, r);
    end
    repeat (5) @(posedge clk);
    bus_read(1'b0, 32'hBFF8, d, r, c);
    tests++;
    if (d !== 32'(c) || r !== 2'b00) begin
      fails++;
      $display("FAIL mtime_lo_div1: got %h/%b required %h/00", d, r, 32'(c));
    end
    bus_read(1'b0, 32'hBFFC, d, r, c);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL mtime_hi_div1: got %h required 00000000", d);
    end
    bus_read(1'b1, 32'hBFF8, d, r, c);
    tests++;
    if (d !== 32'(c / 4)) begin
      fails++;
      $display("FAIL mtime_lo_div4: got %h required %h", d, 32'(c / 4));
    end
  endtask

  task automatic test_timer_cmp();
    logic [1:0] r;
    do_reset();
    bus_write(1'b0, 32'h4000, 32'h0000_0020, 4'hF, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL cmp0_lo_bresp: got %b required 00", r); end
    bus_write(1'b0, 32'h4004, 32'h0000_0000, 4'hF, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL cmp0_hi_bresp: got %b required 00", r); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if (time_intr_a !== {1'b0, (cyc >= 32)}) begin
        fails++;
        $display("FAIL time_intr_poll mtime=%0d: got %b required %b", cyc, time_intr_a, {1'b0, (cyc >= 32)});
      end
    end
  endtask

  task automatic test_msip();
    logic [31:0] d;
    logic [1:0]  r;
    int          c;
    bus_write(1'b0, 32'h0004, 32'h0000_0001, 4'hF, r);
    tests++;
    if (soft_intr_a !== 2'b10) begin fails++; $display("FAIL msip1_set: got %b required 10", soft_intr_a); end
    bus_read(1'b0, 32'h0004, d, r, c);
    tests++;
    if (d !== 32'h1 || r !== 2'b00) begin
      fails++;
      $display("FAIL msip1_read: got %h/%b required 00000001/00", d, r);
    end
    bus_write(1'b0, 32'h0004, 32'h0000_0000, 4'b1110, r);
    tests++;
    if (soft_intr_a !== 2'b10) begin fails++; $display("FAIL msip1_strb: got %b required 10", soft_intr_a); end
    bus_write(1'b0, 32'h0004, 32'h0000_0000, 4'hF, r);
    tests++;
    if (soft_intr_a !== 2'b00) begin fails++; $display("FAIL msip1_clear: got %b required 00", soft_intr_a); end
  endtask

  task automatic test_decode_err();
    logic [31:0] d;
    logic [1:0]  r;
    int          c;
    bus_read(1'b0, 32'h0008, d, r, c);
    tests++;
    if (d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL err_rd_msip2: got %h/%b required 00000000/10", d, r); end
    bus_read(1'b0, 32'h4002, d, r, c);
    tests++;
    if (d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL err_rd_unaligned: got %h/%b required 00000000/10", d, r); end
    bus_read(1'b0, 32'h4010, d, r, c);
    tests++;
    if (d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL err_rd_cmp2: got %h/%b required 00000000/10", d, r); end
    bus_write(1'b0, 32'h5000, 32'hFFFF_FFFF, 4'hF, r);
    tests++;
    if (r !== 2'b10) begin fails++; $display("FAIL err_wr_5000: got %b required 10", r); end
    bus_write(1'b0, 32'h0008, 32'h0000_0001, 4'hF, r);
    tests++;
    if (r !== 2'b10 || soft_intr_a !== 2'b00) begin
      fails++;
      $display("FAIL err_wr_msip2: got %b/%b required 10/00", r, soft_intr_a);
    end
    bus_read(1'b0, 32'h4000, d, r, c);
    tests++;
    if (d !== 32'h20) begin fails++; $display("FAIL cmp0_lo_kept: got %h required 00000020", d); end
    bus_read(1'b0, 32'h4004, d, r, c);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL cmp0_hi_kept: got %h required 00000000", d); end
    bus_write(1'b0, 32'h4008, 32'h1234_5678, 4'b0101, r);
    bus_read(1'b0, 32'h4008, d, r, c);
    tests++;
    if (d !== 32'hFF34_FF78) begin fails++; $display("FAIL cmp1_lo_strb: got %h required ff34ff78", d); end
    bus_write(1'b0, 32'h400C, 32'h0000_0000, 4'b0000, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL strb0_bresp: got %b required 00", r); end
    bus_read(1'b0, 32'h400C, d, r, c);
    tests++;
    if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL strb0_nochange: got %h required ffffffff", d); end
  endtask

  task automatic test_tick_div();
    logic [1:0] r;
    int         lo_exp;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests++;
      if (mtime_b !== 64'(cyc / 4)) begin
        fails++;
        $display("FAIL div4_step edge=%0d: got %h required %h", cyc, mtime_b, 64'(cyc / 4));
      end
    end
    // Stop one negedge early so the write commits on an edge where the prescaler wraps.
    do @(negedge clk); while (cyc % 4 != 2);
    lo_exp = (cyc + 1) / 4;
    bus_write(1'b1, 32'hBFFC, 32'h0000_0001, 4'hF, r);
    tests++;
    if (mtime_b !== {32'h1, 32'(lo_exp)}) begin
      fails++;
      $display("FAIL div4_hi_write: got %h required %h", mtime_b, {32'h1, 32'(lo_exp)});
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (mtime_b !== {32'h1, 32'(lo_exp)}) begin
      fails++;
      $display("FAIL div4_presc_restart: got %h required %h", mtime_b, {32'h1, 32'(lo_exp)});
    end
    @(posedge clk); #1;
    tests++;
    if (mtime_b !== {32'h1, 32'(lo_exp + 1)}) begin
      fails++;
      $display("FAIL div4_next_tick: got %h required %h", mtime_b, {32'h1, 32'(lo_exp + 1)});
    end
  endtask

  task automatic test_back_to_back();
    // AW presented alone for three cycles: nothing may be accepted.
    @(negedge clk);
    awaddr = 32'h0000; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({awready_a, wready_a, bvalid_a, soft_intr_a} !== 5'b11000) begin
        fails++;
        $display("FAIL aw_alone cyc%0d: got %b required 11000", i, {awready_a, wready_a, bvalid_a, soft_intr_a});
      end
    end
    wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({bvalid_a, awready_a, wready_a, bresp_a, soft_intr_a} !== 7'b100_00_01) begin
        fails++;
        $display("FAIL b_held cyc%0d: got %b required 1000001", i,
                 {bvalid_a, awready_a, wready_a, bresp_a, soft_intr_a});
      end
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    tests++;
    if ({bvalid_a, awready_a, wready_a} !== 3'b011) begin
      fails++;
      $display("FAIL b_release: got %b required 011", {bvalid_a, awready_a, wready_a});
    end
    // R held stable while rready is low.
    @(negedge clk);
    araddr = 32'h0000; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({rvalid_a, arready_a, rresp_a, rdata_a} !== {1'b1, 1'b0, 2'b00, 32'h1}) begin
        fails++;
        $display("FAIL r_held cyc%0d: got %b %b %b %h required 1 0 00 00000001", i,
                 rvalid_a, arready_a, rresp_a, rdata_a);
      end
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    tests++;
    if ({rvalid_a, arready_a} !== 2'b01) begin
      fails++;
      $display("FAIL r_release: got %b required 01", {rvalid_a, arready_a});
    end
    // Read and write of msip0 in the same cycle: read returns the old value.
    @(negedge clk);
    araddr = 32'h0000; arvalid = 1'b1;
    awaddr = 32'h0000; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tests++;
    if ({rvalid_a, bvalid_a, soft_intr_a} !== 4'b1100 || rdata_a !== 32'h1) begin
      fails++;
      $display("FAIL rw_same_cycle: got %b rdata=%h required 1100 rdata=00000001",
               {rvalid_a, bvalid_a, soft_intr_a}, rdata_a);
    end
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    // Reset during a pending B aborts it.
    @(negedge clk);
    awaddr = 32'h0000; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({bvalid_a, awready_a, soft_intr_a} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_abort: got %b required 0100", {bvalid_a, awready_a, soft_intr_a});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mtime_read();
    test_timer_cmp();
    test_msip();
    test_decode_err();
    test_tick_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
